// File: rtl/vga_console.sv
// vga_console: terminal-style write sequencer (cursor, CR/LF/BS, wrap, clear, scroll) for a VGA text buffer.
// Latency: one write cycle per printable byte; clears and scroll copies make one buffer access per cycle.
// Backpressure: in_ready only while idle. Optional scroll-on-last-row via macro VGA_CONSOLE_SCROLL_EN.
module vga_console #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_char,
    output logic        in_ready,
    output logic [31:0] buf_addr,
    output logic        buf_we,
    output logic [7:0]  buf_wdata,
    input  logic [7:0]  buf_rdata,
    output logic [7:0]  cursor_x,
    output logic [7:0]  cursor_y,
    output logic        busy
);
    localparam logic [2:0] INIT_CLR  = 3'd0;
    localparam logic [2:0] IDLE      = 3'd1;
    localparam logic [2:0] WRITE     = 3'd2;
    localparam logic [2:0] ROW_CLR   = 3'd3;
`ifdef VGA_CONSOLE_SCROLL_EN
    localparam logic [2:0] SCROLL_RD = 3'd4;
    localparam logic [2:0] SCROLL_WR = 3'd5;
    localparam logic [31:0] COPY_LAST = 32'(COLS * (ROWS - 1) - 1);
    localparam logic [31:0] CLR_BASE  = 32'(COLS * (ROWS - 1));
    localparam logic [31:0] CLR_END   = 32'(COLS * ROWS - 1);
`else
    localparam logic [31:0] CLR_END   = 32'(COLS - 1);
`endif
    localparam logic [31:0] COLS32    = 32'(COLS);
    localparam logic [31:0] LAST_ADDR = 32'(COLS * ROWS - 1);
    localparam logic [7:0]  X_LAST    = 8'(COLS - 1);
    localparam logic [7:0]  Y_LAST    = 8'(ROWS - 1);

    // What the WRITE cycle does to the cursor when it ends
    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_ADV  = 2'd1;
    localparam logic [1:0] K_BACK = 2'd2;

    logic [2:0]  state;
    logic [31:0] addr;
    logic [7:0]  wdata_q;
    logic        wr_en;
    logic [1:0]  kind;
    logic [31:0] cursor_addr;
    logic [2:0]  adv_state;
    logic [7:0]  adv_y;

    assign cursor_addr = {24'd0, cursor_y} * COLS32 + {24'd0, cursor_x};

    // Row advance: next row, or the last-row sequence (scroll, or wrap to a cleared row 0)
    always_comb begin
        adv_state = IDLE;
        adv_y     = cursor_y + 8'd1;
        if (cursor_y == Y_LAST) begin
`ifdef VGA_CONSOLE_SCROLL_EN
            adv_state = SCROLL_RD;
            adv_y     = Y_LAST;
`else
            adv_state = ROW_CLR;
            adv_y     = 8'd0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= INIT_CLR;
            addr     <= '0;
            wdata_q  <= 8'h20;
            wr_en    <= 1'b0;
            kind     <= K_NONE;
            cursor_x <= 8'd0;
            cursor_y <= 8'd0;
        end else begin
            case (state)
                INIT_CLR: begin
                    if (addr == LAST_ADDR) begin
                        state <= IDLE;
                        addr  <= '0;
                    end else begin
                        addr <= addr + 32'd1;
                    end
                end
                IDLE: begin
                    if (in_valid) begin
                        kind  <= K_NONE;
                        wr_en <= 1'b0;
                        state <= WRITE;
                        case (in_char)
                            8'h0D: cursor_x <= 8'd0;
                            8'h0A: begin
                                cursor_x <= 8'd0;
                                cursor_y <= adv_y;
                                addr     <= '0;
                                if (cursor_y == Y_LAST) state <= adv_state;
                            end
                            8'h08: begin
                                if (cursor_x != 8'd0) begin
                                    kind    <= K_BACK;
                                    wr_en   <= 1'b1;
                                    wdata_q <= 8'h20;
                                    addr    <= cursor_addr - 32'd1;
                                end
                            end
                            default: begin
                                kind    <= K_ADV;
                                wr_en   <= 1'b1;
                                wdata_q <= in_char;
                                addr    <= cursor_addr;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    state <= IDLE;
                    wr_en <= 1'b0;
                    if (kind == K_BACK) begin
                        cursor_x <= cursor_x - 8'd1;
                    end else if (kind == K_ADV) begin
                        if (cursor_x == X_LAST) begin
                            cursor_x <= 8'd0;
                            cursor_y <= adv_y;
                            state    <= adv_state;
                            addr     <= '0;
                        end else begin
                            cursor_x <= cursor_x + 8'd1;
                        end
                    end
                end
`ifdef VGA_CONSOLE_SCROLL_EN
                SCROLL_RD: state <= SCROLL_WR;
                SCROLL_WR: begin
                    if (addr == COPY_LAST) begin
                        state <= ROW_CLR;
                        addr  <= CLR_BASE;
                    end else begin
                        state <= SCROLL_RD;
                        addr  <= addr + 32'd1;
                    end
                end
`endif
                ROW_CLR: begin
                    if (addr == CLR_END) begin
                        state <= IDLE;
                        addr  <= '0;
                    end else begin
                        addr <= addr + 32'd1;
                    end
                end
                default: begin
                    state <= INIT_CLR;
                    addr  <= '0;
                end
            endcase
        end
    end

    assign in_ready = (state == IDLE) && !reset;
    assign busy     = !in_ready;

`ifdef VGA_CONSOLE_SCROLL_EN
    // Read the source row one cycle ahead; the copy write uses the returned data
    assign buf_addr  = (state == SCROLL_RD) ? addr + COLS32 : addr;
    assign buf_we    = !reset && ((state == INIT_CLR) || (state == ROW_CLR) ||
                                  (state == SCROLL_WR) || ((state == WRITE) && wr_en));
    assign buf_wdata = (state == WRITE) ? wdata_q :
                       (state == SCROLL_WR) ? buf_rdata : 8'h20;
`else
    logic unused_rdata;
    assign unused_rdata = ^buf_rdata;
    assign buf_addr  = addr;
    assign buf_we    = !reset && ((state == INIT_CLR) || (state == ROW_CLR) ||
                                  ((state == WRITE) && wr_en));
    assign buf_wdata = (state == WRITE) ? wdata_q : 8'h20;
`endif

endmodule

// File: doc/vga_console.md
# vga_console

Terminal-style write sequencer for the VGA text buffer. Accepts a byte stream over a valid/ready handshake, tracks the cursor, and writes the character buffer's write port. It handles CR, LF, backspace, line wrap and full-screen scroll, the last by copying rows through the buffer's read port. It sits between a character source (CPU/UART) and the text buffer that the display controller reads.

## Interface
- COLS, 80: characters per row (1..255)
- ROWS, 30: rows per screen (2..255)
- clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  source has a byte
- in_char  in  8  byte to process
- in_ready  out  1  block accepts a byte this cycle
- buf_addr  out  32  buffer address, y*COLS+x, zero-extended
- buf_we  out  1  write strobe, one write per high cycle
- buf_wdata  out  8  write data
- buf_rdata  in  8  buffer read data; valid the cycle after buf_addr is presented
- cursor_x  out  8  current column
- cursor_y  out  8  current row
- busy  out  1  equals !in_ready

## Operation
- Handshake: a byte is accepted on an edge where in_valid && in_ready. in_ready is high only in IDLE. in_char is sampled only at acceptance.
- States: INIT_CLR, IDLE, WRITE, SCROLL_RD, SCROLL_WR, ROW_CLR.
- INIT_CLR: writes 0x20 to addresses 0..COLS*ROWS-1, one per cycle, then goes to IDLE.
- 0x20..0x7E and any other non-control byte: WRITE puts the byte at the cursor. Then x+1. If x was COLS-1: x=0 and row advance.
- 0x0D (CR): x=0, no write, back to IDLE.
- 0x0A (LF): x=0 plus row advance, no write.
- 0x08 (BS): if x>0, x-1 and WRITE 0x20 at the new position. If x==0, no-op.
- Row advance: if y<ROWS-1, then y+1 and go to IDLE. Otherwise scroll.
- Scroll:
  - For dst=0..COLS*(ROWS-1)-1: SCROLL_RD presents addr dst+COLS with we=0. SCROLL_WR presents addr dst with we=1 and wdata=buf_rdata.
  - Then ROW_CLR writes 0x20 across row ROWS-1.
  - y stays ROWS-1.
- Cursor outputs update on the edge that ends WRITE, or at acceptance for CR/LF/BS-at-0.
- In IDLE: buf_we=0.

## Timing
- Reset values: in_ready=0, busy=1, buf_we=0, buf_addr=0, buf_wdata=0x20, cursor_x=0, cursor_y=0. State=INIT_CLR.
- Reset mid-operation (any state) aborts the operation and restarts INIT_CLR from address 0.
- INIT_CLR: first cycle after reset deasserts has buf_we=1, addr 0. in_ready rises COLS*ROWS cycles later.
- Printable byte accepted at edge k:
  - Cycle after k has buf_we=1 with addr and data.
  - in_ready is high again after edge k+1, giving throughput of 1 byte per 2 cycles.
- CR/LF without scroll: in_ready drops for exactly one cycle.
- Scroll duration after triggering: 2*COLS*(ROWS-1)+COLS cycles. For 80x30 this is 4720.
- Printable byte at (COLS-1, ROWS-1): WRITE, then scroll, then IDLE.
- Address arithmetic is done in 32 bits. It never exceeds COLS*ROWS-1.

## Configuration
- VGA_CONSOLE_SCROLL_EN defined: row advance from the last row scrolls as above.
- VGA_CONSOLE_SCROLL_EN undefined:
  - Row advance from the last row sets y=0 and runs ROW_CLR on row 0, taking COLS cycles.
  - SCROLL_RD/SCROLL_WR are not built, and buf_rdata is unused.

## Test plan
- Reset, then hold in_valid=0. Expect exactly 2400 buf_we pulses, addresses 0..2399, data 0x20. in_ready rises on cycle 2400; cursor stays (0,0).
- Send "AB" after init. Expect a write of 0x41 @0, then 0x42 @1. cursor_x=2, with in_ready low for 1 cycle after each accept.
- Send 80×'x' then 'y'. Expect 'y' written @80 and cursor at (1,1). Then send BS, BS: expect 0x20 written @80, then no write; cursor ends at (0,1).
- Send "\r" at (5,3): expect no write and cursor (0,3). Send "\n" at (5,3): expect cursor (0,4).
- With SCROLL_EN, preload row 1 via writes, put the cursor on row 29, send LF.
  - Expect buffer row 0 equals the old row 1, and row 29 is all 0x20.
  - Expect 4720 busy cycles and cursor (0,29).
  - Without SCROLL_EN: expect cursor (0,0), row 0 cleared in 80 writes.
- Assert reset for 1 cycle in the middle of a scroll. Expect the next cycle to show buf_we=1 @0 with data 0x20 and cursor (0,0), and the full 2400-write init to repeat.
